// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared types and defaults for the operand-stack controller
package stack_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 16;

  // Encoding matches the op_code pins directly.
  typedef enum logic [1:0] {
    PUSH_R = 2'b00,
    POP_R  = 2'b01,
    PUSH_I = 2'b10,
    DROP   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEL  = 2'b01,
    XFER = 2'b10,
    DONE = 2'b11
  } state_e;

  function automatic logic is_push(input op_e op);
    return (op == PUSH_R) || (op == PUSH_I);
  endfunction

endpackage

// File: rtl/lifo_mem.sv
// rtl/lifo_mem.sv - stack storage array, synchronous write, asynchronous read
//
// Ports:
//   clk    - write clock
//   we     - write enable
//   waddr  - write index
//   wdata  - write word
//   raddr  - read index
//   rdata  - read word (combinational from raddr)
//
// The array is not reset; the controller never reads above the top of stack,
// so stale contents are unobservable.
module lifo_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]           wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]           rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/stack_xfer_unit.sv
// rtl/stack_xfer_unit.sv - operand-stack controller exchanging words with the register bank
//
// Ports:
//   clk, reset            - clock, asynchronous active-low reset
//   op_valid / op_ready   - operation handshake (ready only in IDLE)
//   op_code, op_reg,
//   op_imm                - operation, register index, immediate (captured at accept)
//   done, err             - one-cycle completion pulse, error flag valid with done
//   rId, ldR, rIn         - register select, load strobe, write data to the bank
//   rOut                  - read data from the bank
//   count, full, empty    - stack occupancy
module stack_xfer_unit
  import stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     op_valid,
  output logic                     op_ready,
  input  logic [1:0]               op_code,
  input  logic [2:0]               op_reg,
  input  logic [WIDTH-1:0]         op_imm,
  output logic                     done,
  output logic                     err,
  output logic [2:0]               rId,
  output logic                     ldR,
  output logic [WIDTH-1:0]         rIn,
  input  logic [WIDTH-1:0]         rOut,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] IDX_ONE  = AW'(1);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic             err_q, err_d;
  logic [2:0]       rid_q, rid_d;
  logic [WIDTH-1:0] rin_q, rin_d;
  logic [AW:0]      cnt_q, cnt_d;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [AW-1:0]    mem_raddr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;

  logic             full_w;
  logic             empty_w;
  op_e              op_in;

  assign full_w  = (cnt_q == CNT_FULL);
  assign empty_w = (cnt_q == '0);
  assign op_in   = op_e'(op_code);

  // Top of stack is always count-1; when empty the index wraps but is never used.
  assign mem_waddr = cnt_q[AW-1:0];
  assign mem_raddr = cnt_q[AW-1:0] - IDX_ONE;

  lifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= PUSH_R;
      imm_q   <= '0;
      err_q   <= 1'b0;
      rid_q   <= '0;
      rin_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      imm_q   <= imm_d;
      err_q   <= err_d;
      rid_q   <= rid_d;
      rin_q   <= rin_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    imm_d     = imm_q;
    err_d     = err_q;
    rid_d     = rid_q;
    rin_d     = rin_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_wdata = imm_q;

    unique case (state_q)
      IDLE: begin
        if (op_valid) begin
          op_d  = op_in;
          imm_d = op_imm;
          rid_d = op_reg;
          // Overflow/underflow is rejected here, which is also what keeps
          // count from ever wrapping.
          if ((is_push(op_in) && full_w) || (!is_push(op_in) && empty_w)) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = SEL;
          end
        end
      end

      SEL: begin
        // rId has been stable for a full cycle, and the popped word is
        // captured now so it is on rIn when ldR fires in XFER.
        if (op_q == POP_R) begin
          rin_d = mem_rdata;
        end
        state_d = XFER;
      end

      XFER: begin
        unique case (op_q)
          PUSH_R: begin
            mem_we    = 1'b1;
            mem_wdata = rOut;
            cnt_d     = cnt_q + CNT_ONE;
          end
          PUSH_I: begin
            mem_we    = 1'b1;
            mem_wdata = imm_q;
            cnt_d     = cnt_q + CNT_ONE;
          end
          POP_R,
          DROP: begin
            cnt_d = cnt_q - CNT_ONE;
          end
          default: ;
        endcase
        state_d = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Decoded from registered state so an asynchronous reset cuts them at once.
  assign op_ready = (state_q == IDLE);
  assign done     = (state_q == DONE);
  assign err      = (state_q == DONE) && err_q;
  assign ldR      = (state_q == XFER) && (op_q == POP_R);

  assign rId   = rid_q;
  assign rIn   = rin_q;
  assign count = cnt_q;
  assign full  = full_w;
  assign empty = empty_w;

endmodule

// File: tb/tb_stack_xfer_unit.sv
// tb/tb_stack_xfer_unit.sv - scoreboard bench for stack_xfer_unit with a register-bank model
module tb_stack_xfer_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [1:0]  op_code = 2'b00;
  logic [2:0]  op_reg = 3'd0;
  logic [15:0] op_imm = 16'h0;
  logic        done;
  logic        err;
  logic [2:0]  rId;
  logic        ldR;
  logic [15:0] rIn;
  logic [15:0] rOut;
  logic [4:0]  count;
  logic        full;
  logic        empty;

  stack_xfer_unit #(.WIDTH(16), .DEPTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_code  (op_code),
    .op_reg   (op_reg),
    .op_imm   (op_imm),
    .done     (done),
    .err      (err),
    .rId      (rId),
    .ldR      (ldR),
    .rIn      (rIn),
    .rOut     (rOut),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  // Register bank model: combinational read, write on ldR.
  logic [15:0] bank [8];
  logic        bank_wr = 1'b0;
  logic [2:0]  bank_wa = 3'd0;
  logic [15:0] bank_wd = 16'h0;

  assign rOut = bank[rId];

  always @(posedge clk) begin
    if (ldR) bank[rId] <= rIn;
    else if (bank_wr) bank[bank_wa] <= bank_wd;
  end

  typedef struct {
    logic       err;
    int         acc;
    int         lat;
    int         cnt;
    logic [2:0] rid;
  } exp_t;

  typedef struct {
    logic [2:0]  rid;
    logic [15:0] val;
  } rin_t;

  exp_t        exp_q[$];
  rin_t        rin_q[$];
  logic [15:0] model[$];

  int tests = 0;
  int fails = 0;
  int ncyc = 0;
  int acc_last = 0;
  int acc_prev = 0;
  logic ldr_prev = 1'b0;

  // Output monitor: pops expectations as done / ldR appear.
  exp_t me;
  rin_t mr;
  always begin
    @(negedge clk);
    ncyc++;
    if (reset) begin
      if (done) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done: done=1 at cycle %0d, required 0", ncyc);
        end else begin
          me = exp_q.pop_front();
          tests += 4;
          if (err !== me.err) begin
            fails++; $display("FAIL done_err: err=%0b required %0b", err, me.err);
          end
          if (ncyc - me.acc !== me.lat) begin
            fails++; $display("FAIL done_latency: latency=%0d required %0d", ncyc - me.acc, me.lat);
          end
          if (count !== 5'(me.cnt)) begin
            fails++; $display("FAIL done_count: count=%0d required %0d", count, me.cnt);
          end
          if (rId !== me.rid) begin
            fails++; $display("FAIL done_rid: rId=%0d required %0d", rId, me.rid);
          end
        end
      end
      if (ldR) begin
        tests++;
        if (ldr_prev) begin
          fails++; $display("FAIL ldr_width: ldR high for more than one cycle");
        end
        if (rin_q.size() == 0) begin
          fails++; $display("FAIL unexpected_ldr: ldR=1 required 0");
        end else begin
          mr = rin_q.pop_front();
          tests += 2;
          if (rIn !== mr.val) begin
            fails++; $display("FAIL ldr_rin: rIn=%h required %h", rIn, mr.val);
          end
          if (rId !== mr.rid) begin
            fails++; $display("FAIL ldr_rid: rId=%0d required %0d", rId, mr.rid);
          end
        end
      end
      ldr_prev = ldR;
    end else begin
      ldr_prev = 1'b0;
    end
  end

  task automatic issue_op(input logic [1:0] code, input logic [2:0] r,
                          input logic [15:0] imm, input bit hold);
    int t = 0;
    logic e = 1'b0;
    @(negedge clk); #1;
    op_code = code; op_reg = r; op_imm = imm; op_valid = 1'b1;
    while (op_ready !== 1'b1 && t < 20) begin
      @(negedge clk); #1; t++;
    end
    if (t >= 20) begin
      tests++; fails++;
      $display("FAIL accept_timeout: op_ready=%0b required 1", op_ready);
      op_valid = 1'b0;
      return;
    end
    case (code)
      2'b00: if (model.size() == 16) e = 1'b1; else model.push_back(bank[r]);
      2'b10: if (model.size() == 16) e = 1'b1; else model.push_back(imm);
      2'b01: if (model.size() == 0) e = 1'b1;
             else rin_q.push_back('{rid: r, val: model.pop_back()});
      default: if (model.size() == 0) e = 1'b1; else void'(model.pop_back());
    endcase
    exp_q.push_back('{err: e, acc: ncyc, lat: (e ? 1 : 3), cnt: model.size(), rid: r});
    acc_prev = acc_last;
    acc_last = ncyc;
    @(posedge clk); #1;
    if (hold) begin
      op_code = 2'($urandom); op_reg = 3'($urandom); op_imm = 16'($urandom);
    end else begin
      op_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || rin_q.size() != 0) && t < 40) begin
      @(negedge clk); #1; t++;
    end
    tests++;
    if (t >= 40) begin
      fails++;
      $display("FAIL idle_timeout: pending=%0d required 0", exp_q.size() + rin_q.size());
      exp_q.delete(); rin_q.delete();
    end
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests += 9;
    if (op_ready !== 1'b1) begin fails++; $display("FAIL rst_op_ready: %0b required 1", op_ready); end
    if (done !== 1'b0)     begin fails++; $display("FAIL rst_done: %0b required 0", done); end
    if (err !== 1'b0)      begin fails++; $display("FAIL rst_err: %0b required 0", err); end
    if (ldR !== 1'b0)      begin fails++; $display("FAIL rst_ldr: %0b required 0", ldR); end
    if (rId !== 3'd0)      begin fails++; $display("FAIL rst_rid: %0d required 0", rId); end
    if (rIn !== 16'h0)     begin fails++; $display("FAIL rst_rin: %h required 0000", rIn); end
    if (count !== 5'd0)    begin fails++; $display("FAIL rst_count: %0d required 0", count); end
    if (empty !== 1'b1)    begin fails++; $display("FAIL rst_empty: %0b required 1", empty); end
    if (full !== 1'b0)     begin fails++; $display("FAIL rst_full: %0b required 0", full); end
    reset = 1'b1;
  endtask

  task automatic test_push_imm();
    issue_op(2'b10, 3'd0, 16'h1234, 1'b0);
    wait_idle();
    tests += 2;
    if (count !== 5'd1) begin fails++; $display("FAIL push_imm_count: %0d required 1", count); end
    if (empty !== 1'b0) begin fails++; $display("FAIL push_imm_empty: %0b required 0", empty); end
    issue_op(2'b11, 3'd1, 16'h0, 1'b0);
    wait_idle();
    tests++;
    if (empty !== 1'b1) begin fails++; $display("FAIL drop_empty: %0b required 1", empty); end
  endtask

  task automatic test_bank_xfer();
    @(negedge clk);
    bank_wr = 1'b1; bank_wa = 3'd5; bank_wd = 16'hBEEF;
    @(negedge clk);
    bank_wr = 1'b0;
    issue_op(2'b00, 3'd5, 16'h0, 1'b0);
    wait_idle();
    issue_op(2'b01, 3'd2, 16'h0, 1'b0);
    wait_idle();
    tests += 2;
    if (bank[2] !== 16'hBEEF) begin fails++; $display("FAIL bank_r2: %h required beef", bank[2]); end
    if (count !== 5'd0) begin fails++; $display("FAIL bank_count: %0d required 0", count); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) begin
      issue_op(2'b10, 3'(i), 16'(i), 1'b0);
    end
    wait_idle();
    tests++;
    if (full !== 1'b1) begin fails++; $display("FAIL full_flag: %0b required 1", full); end
    issue_op(2'b10, 3'd7, 16'hDEAD, 1'b0);
    wait_idle();
    tests++;
    if (count !== 5'd16) begin fails++; $display("FAIL overflow_count: %0d required 16", count); end
    for (int i = 0; i < 16; i++) begin
      issue_op(2'b01, 3'(i), 16'h0, 1'b0);
    end
    wait_idle();
    tests++;
    if (empty !== 1'b1) begin fails++; $display("FAIL drain_empty: %0b required 1", empty); end
  endtask

  task automatic test_empty_err();
    issue_op(2'b01, 3'd3, 16'h0, 1'b0);
    wait_idle();
    issue_op(2'b11, 3'd4, 16'h0, 1'b0);
    wait_idle();
    tests++;
    if (count !== 5'd0) begin fails++; $display("FAIL underflow_count: %0d required 0", count); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  codes [4] = '{2'b10, 2'b10, 2'b01, 2'b11};
    logic [15:0] imms  [4] = '{16'hA5A5, 16'h0F0F, 16'h0, 16'h0};
    for (int i = 0; i < 4; i++) begin
      issue_op(codes[i], 3'(i + 3), imms[i], (i != 3));
      if (i > 0) begin
        tests++;
        if (acc_last - acc_prev !== 4) begin
          fails++; $display("FAIL b2b_spacing: %0d cycles required 4", acc_last - acc_prev);
        end
      end
    end
    wait_idle();
    tests++;
    if (count !== 5'd0) begin fails++; $display("FAIL b2b_count: %0d required 0", count); end
  endtask

  task automatic test_reset_mid();
    issue_op(2'b10, 3'd0, 16'h7777, 1'b0);
    wait_idle();
    issue_op(2'b01, 3'd1, 16'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    tests += 4;
    if (ldR !== 1'b0)      begin fails++; $display("FAIL mid_ldr: %0b required 0", ldR); end
    if (op_ready !== 1'b1) begin fails++; $display("FAIL mid_op_ready: %0b required 1", op_ready); end
    if (count !== 5'd0)    begin fails++; $display("FAIL mid_count: %0d required 0", count); end
    if (done !== 1'b0)     begin fails++; $display("FAIL mid_done: %0b required 0", done); end
    exp_q.delete();
    model.delete();
    tests++;
    if (rin_q.size() != 0) begin
      fails++; $display("FAIL mid_ldr_seen: pending=%0d required 0", rin_q.size());
      rin_q.delete();
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    issue_op(2'b10, 3'd6, 16'h5A5A, 1'b0);
    wait_idle();
    tests++;
    if (count !== 5'd1) begin fails++; $display("FAIL post_rst_count: %0d required 1", count); end
  endtask

  initial begin
    test_reset();
    test_push_imm();
    test_bank_xfer();
    test_full();
    test_empty_err();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
